// File: rtl/ram_stream_loader.sv
// ram_stream_loader
// Purpose : write-side initiator for the single-port RAM; packs a big-endian
//           byte stream into 16-bit words written to auto-incrementing
//           addresses starting at a base.
// Latency : one word per 3 cycles minimum (HI, LO, WRITE), or 5 with read-back verify.
// Backpressure: o_Byte_Ready is high only while waiting for a high or low byte;
//           the loader stalls indefinitely on a missing byte.
// Optional feature: define LOADER_VERIFY_EN to read back and compare each word.
// Ports:
//   i_CLK, i_RST                      clock, asynchronous active-high reset
//   i_Start, i_Base_Address, i_Length load request (sampled only in IDLE)
//   i_Byte, i_Byte_Valid, o_Byte_Ready byte stream handshake
//   o_RAM_Address/_Data/_Write_EN     registered RAM write port
//   i_RAM_Data                        RAM read data (1-cycle registered read)
//   o_Busy, o_Done, o_Word_Count, o_Error  status
module ram_stream_loader #(
  parameter int DEPTH = 2**14,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_Start,
  input  logic [AW-1:0]    i_Base_Address,
  input  logic [AW:0]      i_Length,
  input  logic [7:0]       i_Byte,
  input  logic             i_Byte_Valid,
  output logic             o_Byte_Ready,
  output logic [AW-1:0]    o_RAM_Address,
  output logic [WIDTH-1:0] o_RAM_Data,
  output logic             o_RAM_Write_EN,
  input  logic [WIDTH-1:0] i_RAM_Data,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [AW:0]      o_Word_Count,
  output logic             o_Error
);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_VRD, S_VCMP, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_DONE
  } state_t;
`endif

  state_t           r_State;
  logic [7:0]       r_Hi_Byte;
  logic [AW-1:0]    r_Cur_Addr;
  logic [AW:0]      r_Length;
  logic [AW:0]      r_Count;
  logic [AW-1:0]    r_RAM_Address;
  logic [WIDTH-1:0] r_RAM_Data;
  logic             r_RAM_Write_EN;
  logic             r_Done;

  logic             w_Byte_Take;
  logic [AW:0]      w_Count_Next;
  logic [AW-1:0]    w_Addr_Next;
  logic             w_Last_Word;

  assign o_Byte_Ready = (r_State == S_HI) || (r_State == S_LO);
  assign w_Byte_Take  = i_Byte_Valid && o_Byte_Ready;
  assign w_Count_Next = r_Count + 1'b1;
  assign w_Last_Word  = (w_Count_Next == r_Length);
  // Explicit wrap so a non-power-of-two DEPTH still stays in range.
  assign w_Addr_Next  = (r_Cur_Addr == AW'(DEPTH - 1)) ? '0 : r_Cur_Addr + 1'b1;

  assign o_RAM_Address  = r_RAM_Address;
  assign o_RAM_Data     = r_RAM_Data;
  assign o_RAM_Write_EN = r_RAM_Write_EN;
  assign o_Busy         = (r_State != S_IDLE);
  assign o_Done         = r_Done;
  assign o_Word_Count   = r_Count;

`ifdef LOADER_VERIFY_EN
  logic r_Error;
  assign o_Error = r_Error;
`else
  assign o_Error = 1'b0;
  logic w_unused_ram_data;
  assign w_unused_ram_data = ^i_RAM_Data;
`endif

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_State        <= S_IDLE;
      r_Hi_Byte      <= '0;
      r_Cur_Addr     <= '0;
      r_Length       <= '0;
      r_Count        <= '0;
      r_RAM_Address  <= '0;
      r_RAM_Data     <= '0;
      r_RAM_Write_EN <= 1'b0;
      r_Done         <= 1'b0;
`ifdef LOADER_VERIFY_EN
      r_Error        <= 1'b0;
`endif
    end else begin
      // Strobes are set only on entry to their state, so they last one cycle.
      r_RAM_Write_EN <= 1'b0;
      r_Done         <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (i_Start) begin
            r_Cur_Addr <= i_Base_Address;
            r_Length   <= i_Length;
            r_Count    <= '0;
`ifdef LOADER_VERIFY_EN
            r_Error    <= 1'b0;
`endif
            if (i_Length == '0) begin
              r_State <= S_DONE;
              r_Done  <= 1'b1;
            end else begin
              r_State <= S_HI;
            end
          end
        end
        S_HI: begin
          if (w_Byte_Take) begin
            r_Hi_Byte <= i_Byte;
            r_State   <= S_LO;
          end
        end
        S_LO: begin
          if (w_Byte_Take) begin
            r_RAM_Address  <= r_Cur_Addr;
            r_RAM_Data     <= {r_Hi_Byte, i_Byte};
            r_RAM_Write_EN <= 1'b1;
            r_State        <= S_WRITE;
          end
        end
        S_WRITE: begin
`ifdef LOADER_VERIFY_EN
          r_State <= S_VRD;
`else
          r_Count    <= w_Count_Next;
          r_Cur_Addr <= w_Addr_Next;
          if (w_Last_Word) begin
            r_State <= S_DONE;
            r_Done  <= 1'b1;
          end else begin
            r_State <= S_HI;
          end
`endif
        end
`ifdef LOADER_VERIFY_EN
        // Address is held on o_RAM_Address; the RAM captures the read here.
        S_VRD: r_State <= S_VCMP;
        S_VCMP: begin
          if (i_RAM_Data != r_RAM_Data) begin
            // Abort: count is left at the last verified word.
            r_Error <= 1'b1;
            r_State <= S_DONE;
            r_Done  <= 1'b1;
          end else begin
            r_Count    <= w_Count_Next;
            r_Cur_Addr <= w_Addr_Next;
            if (w_Last_Word) begin
              r_State <= S_DONE;
              r_Done  <= 1'b1;
            end else begin
              r_State <= S_HI;
            end
          end
        end
`endif
        S_DONE:  r_State <= S_IDLE;
        default: r_State <= S_IDLE;
      endcase
    end
  end

endmodule
